// File: rtl/id_inst_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer of fetch packets.
// Latency: a packet pushed at edge N is presented at the head after edge N. There is no bypass.
// Backpressure: ds_allowin is ~q_full only, so decode stalls never reach fetch combinationally.
module id_inst_queue #(
    parameter int DATA_WD = 64,
    parameter int DEPTH   = 4,
    parameter int CNT_WD  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fs_to_ds_valid,
    input  logic [DATA_WD-1:0] fs_to_ds_bus,
    output logic               ds_allowin,
    output logic               q_to_id_valid,
    output logic [DATA_WD-1:0] q_to_id_bus,
    input  logic               id_allowin,
    input  logic               flush,
    output logic [CNT_WD-1:0]  q_count,
    output logic               q_full,
    output logic               q_empty
);

    localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WD-1:0] storage [DEPTH];
    logic [PTR_WD-1:0]  rd_ptr;
    logic [PTR_WD-1:0]  wr_ptr;
    logic [CNT_WD-1:0]  count;
    logic               push;
    logic               pop;

    // Full/empty come from the occupancy counter alone; pointers are equal in both cases.
    assign q_count       = count;
    assign q_full        = (count == CNT_WD'(DEPTH));
    assign q_empty       = (count == '0);
    assign ds_allowin    = ~q_full;
    assign q_to_id_valid = ~q_empty;
    assign q_to_id_bus   = storage[rd_ptr];

    // Flush outranks both handshakes, so an offered packet in a flush cycle is dropped.
    assign push = fs_to_ds_valid & ds_allowin & ~flush;
    assign pop  = q_to_id_valid & id_allowin & ~flush;

    // DEPTH is a power of two, so natural pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WD'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WD'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WD'(1);
                2'b01:   count <= count - CNT_WD'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the head is only meaningful while q_to_id_valid is high.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            storage[wr_ptr] <= fs_to_ds_bus;
        end
    end

endmodule
